// File: rtl/tdm_pkg.sv
// tdm_pkg: channel count, select width, state and channel types shared by the TDM mux and demux ends
package tdm_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W = 3;
    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [SEL_W-1:0] ch_t;
endpackage

// File: rtl/mux_8x1.sv
// mux_8x1: combinational selection of one bit of the held word by channel number
module mux_8x1
    import tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] d,
    input  ch_t               sel,
    output logic              y
);
    assign y = d[sel];
endmodule

// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1: serialises an accepted 8-bit word onto one line, one channel per cycle, with registered outputs
module tdm_mux_8x1
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       load,
    output logic       ready,
    output logic       i,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       out_valid,
    output logic       frame
);
    state_t state, state_n;
    ch_t ch, ch_n;
    logic [NUM_CH-1:0] hold, hold_n;
    logic accept, last, bit_n;
    assign last = ch == ch_t'(NUM_CH - 1);
    assign accept = load && ready;
    always_comb begin
        state_n = (state == IDLE || last) ? (accept ? SEND : IDLE) : SEND;
        ch_n = (state == SEND && !last) ? ch + 1'b1 : '0;
        hold_n = accept ? d : hold;
    end
    // outputs are computed from the next-cycle state so they line up with state/ch after the edge
    mux_8x1 u_mux (.d(hold_n), .sel(ch_n), .y(bit_n));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch <= '0;
            hold <= '0;
            ready <= 1'b0;
            i <= 1'b0;
            {s2, s1, s0} <= '0;
            out_valid <= 1'b0;
            frame <= 1'b0;
        end else begin
            state <= state_n;
            ch <= ch_n;
            hold <= hold_n;
            ready <= state_n == IDLE || ch_n == ch_t'(NUM_CH - 1);
            i <= state_n == SEND && bit_n;
            {s2, s1, s0} <= ch_n;
            out_valid <= state_n == SEND;
            frame <= state_n == SEND && ch_n == '0;
        end
    end
endmodule
